// File: rtl/osd_ram_ctrl.sv
// osd_ram_ctrl: single-clock OSD character/attribute buffer.
// One write port and one read port, with a read latency of 1 or 2 (OUTPUT_REG).
// Write-first forwarding. An optional clear engine fills the array with CLR_VALUE.
// Define OSD_RAM_CTRL_CLR_EN to build the clear engine, wr_drop and CLR_VALUE forwarding.
module osd_ram_ctrl #(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    OUTPUT_REG = 0,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_drop,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Effective array write for this cycle: user write or clear-engine write.
  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;

`ifdef OSD_RAM_CTRL_CLR_EN
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                clr_busy_q, clr_busy_d;
  logic                clr_done_q, clr_done_d;
  logic                wr_drop_q, wr_drop_d;

  // Clear FSM next state, write-port arbitration and status outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    wa      = wr_addr;
    wd      = wr_data;
    unique case (state_q)
      IDLE: begin
        we = wr_en;
        // The last busy cycle is spent in IDLE, so the start request is also gated by clr_busy.
        if (clr_start && !clr_busy_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // A reset aborts the clear at once, so the write at the reset edge is suppressed.
        we    = rst_n;
        wa    = cnt_q[ADDR_WIDTH-1:0];
        wd    = CLR_VALUE;
        cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        we      = wr_en;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Busy also covers the cycle after DONE. That gives 2^ADDR_WIDTH+2 busy cycles in total.
    clr_busy_d = (state_d != IDLE) || (state_q == DONE);
    clr_done_d = (state_d == DONE);
    wr_drop_d  = wr_en && (state_q == CLEAR);
  end

  // Clear FSM state, counter and registered status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;
`else
  logic clr_start_unused;
  assign clr_start_unused = clr_start;

  // Without the clear engine every user write is accepted.
  always_comb begin
    we = wr_en;
    wa = wr_addr;
    wd = wr_data;
  end

  assign clr_busy = 1'b0;
  assign clr_done = 1'b0;
  assign wr_drop  = 1'b0;
`endif

  // Array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset so it maps onto block RAM.
    if (we) mem[wa] <= wd;
  end

  logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
  logic                  rd1_valid_q, rd1_valid_d;

  // First read stage: a same-address write in this cycle is forwarded (write-first).
  always_comb begin
    rd1_valid_d = rd_en;
    rd1_data_d  = rd1_data_q;
    if (rd_en) rd1_data_d = (we && (wa == rd_addr)) ? wd : mem[rd_addr];
  end

  // First read stage register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd1_data_q  <= '0;
      rd1_valid_q <= 1'b0;
    end else begin
      rd1_data_q  <= rd1_data_d;
      rd1_valid_q <= rd1_valid_d;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd2_data_q, rd2_data_d;
      logic                  rd2_valid_q, rd2_valid_d;

      // Second stage: hold the data when no read reaches it.
      always_comb begin
        rd2_valid_d = rd1_valid_q;
        rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
      end

      // Second read stage register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd2_data_q  <= '0;
          rd2_valid_q <= 1'b0;
        end else begin
          rd2_data_q  <= rd2_data_d;
          rd2_valid_q <= rd2_valid_d;
        end
      end

      assign rd_data  = rd2_data_q;
      assign rd_valid = rd2_valid_q;
    end else begin : g_noreg
      assign rd_data  = rd1_data_q;
      assign rd_valid = rd1_valid_q;
    end
  endgenerate

endmodule
